radio_deserializer: RTL and testbench

//   Receive end of the radio sample link. Recovers 8-bit radio samples from the
//   1-bit LSB-first serial stream: one bit per SYS_CLK, bit 0 flagged by SYNC_IN.

---
 rtl/radio_deserializer_if.sv | 38 +++
 rtl/radio_deserializer.sv | 196 +++++++++++++++++++
 tb/tb_radio_deserializer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/radio_deserializer_if.sv
// Radio sample link bundle: serial stream in, word handshake and status out.
interface radio_deserializer_if;
    localparam int unsigned WORD_W = 8;
    localparam int unsigned ERR_W  = 8;

    logic              data_in;
    logic              sync_in;
    logic [WORD_W-1:0] sample;
    logic              sample_valid;
    logic              sample_ready;
    logic              locked;
    logic              overflow;
    logic [ERR_W-1:0]  err_cnt;

    // Link/consumer side: drives the serial stream and accepts words.
    modport master (
        output data_in,
        output sync_in,
        output sample_ready,
        input  sample,
        input  sample_valid,
        input  locked,
        input  overflow,
        input  err_cnt
    );

    // Deserializer side.
    modport slave (
        input  data_in,
        input  sync_in,
        input  sample_ready,
        output sample,
        output sample_valid,
        output locked,
        output overflow,
        output err_cnt
    );
endinterface

// File: rtl/radio_deserializer.sv
// Receive end of the radio sample link: recovers 8-bit LSB-first words from a
// 1-bit stream framed by a bit-0 sync pulse, tracks frame lock (HUNT/ALIGN/
// LOCKED) and queues words in a 2-entry output FIFO.
// Optional build macro RADIO_DESER_STATS_EN enables the saturating error
// counter on err_cnt; without it err_cnt is tied to zero.
module radio_deserializer #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 2
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    radio_deserializer_if.slave  link
);
    localparam int unsigned WORD_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MISS_W = $clog2(LOSS_COUNT + 1);
    localparam int unsigned FILL_W = 2;
    localparam int unsigned ERR_W  = 8;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  bitcnt;
    // Bit 0 of the shift window is never observed: a word is taken from
    // data_in plus the seven most recent bits, so only those are stored.
    logic [WORD_W-1:1] shreg;
    logic [GOOD_W-1:0] good;
    logic [GOOD_W-1:0] good_nxt;
    logic [MISS_W-1:0] miss;
    logic [MISS_W-1:0] miss_nxt;
    logic [WORD_W-1:0] tail;
    logic [FILL_W-1:0] fill;

    logic              boundary_c;
    logic              word_done_c;
    logic [WORD_W-1:0] word_c;
    logic              push_c;
    logic              pop_c;
    logic              drop_c;

    assign boundary_c  = (bitcnt == CNT_W'(0));
    assign word_done_c = (bitcnt == CNT_W'(WORD_W - 1));
    assign word_c      = {link.data_in, shreg};
    assign pop_c       = link.sample_valid & link.sample_ready;
    assign drop_c      = push_c & ~pop_c & (fill == FILL_W'(2));

    // Bit position tracking and serial shift; sync restarts the frame at bit 1.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            bitcnt <= CNT_W'(0);
            shreg  <= '0;
        end else begin
            shreg <= {link.data_in, shreg[WORD_W-1:2]};
            if (link.sync_in) begin
                bitcnt <= CNT_W'(1);
            end else begin
                bitcnt <= bitcnt + CNT_W'(1);
            end
        end
    end

    // Lock FSM state, qualification counters and registered lock flag.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state       <= ST_HUNT;
            good        <= GOOD_W'(0);
            miss        <= MISS_W'(0);
            link.locked <= 1'b0;
        end else begin
            state       <= state_nxt;
            good        <= good_nxt;
            miss        <= miss_nxt;
            link.locked <= (state_nxt == ST_LOCKED);
        end
    end

    // Lock FSM next state and word push decision.
    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        miss_nxt  = miss;
        push_c    = 1'b0;
        unique case (state)
            ST_HUNT: begin
                if (link.sync_in) begin
                    state_nxt = ST_ALIGN;
                    good_nxt  = GOOD_W'(1);
                end
            end
            ST_ALIGN: begin
                if (link.sync_in && !boundary_c) begin
                    // Realign to the new phase and restart qualification.
                    good_nxt = GOOD_W'(1);
                end else if (boundary_c) begin
                    if (link.sync_in) begin
                        good_nxt = good + GOOD_W'(1);
                        if (good_nxt == GOOD_W'(LOCK_COUNT)) begin
                            state_nxt = ST_LOCKED;
                            miss_nxt  = MISS_W'(0);
                        end
                    end else begin
                        state_nxt = ST_HUNT;
                    end
                end
            end
            ST_LOCKED: begin
                if (link.sync_in && !boundary_c) begin
                    // Off-phase sync: partial word (even one completing now) is dropped.
                    state_nxt = ST_ALIGN;
                    good_nxt  = GOOD_W'(1);
                end else if (boundary_c) begin
                    if (link.sync_in) begin
                        miss_nxt = MISS_W'(0);
                    end else begin
                        miss_nxt = miss + MISS_W'(1);
                        if (miss_nxt == MISS_W'(LOSS_COUNT)) begin
                            state_nxt = ST_HUNT;
                        end
                    end
                end else if (word_done_c) begin
                    push_c = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_HUNT;
            end
        endcase
    end

    // Two-entry output FIFO: sample register is the head, tail holds the second word.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            fill              <= FILL_W'(0);
            tail              <= '0;
            link.sample       <= '0;
            link.sample_valid <= 1'b0;
            link.overflow     <= 1'b0;
        end else begin
            if (pop_c) begin
                if (fill == FILL_W'(2)) begin
                    link.sample <= tail;
                    if (push_c) begin
                        tail <= word_c;
                    end else begin
                        fill <= FILL_W'(1);
                    end
                end else if (push_c) begin
                    link.sample <= word_c;
                end else begin
                    fill              <= FILL_W'(0);
                    link.sample_valid <= 1'b0;
                end
            end else if (push_c) begin
                if (fill == FILL_W'(0)) begin
                    link.sample       <= word_c;
                    link.sample_valid <= 1'b1;
                    fill              <= FILL_W'(1);
                end else if (fill == FILL_W'(1)) begin
                    tail <= word_c;
                    fill <= FILL_W'(2);
                end
            end
            if (drop_c) begin
                link.overflow <= 1'b1;
            end
        end
    end

`ifdef RADIO_DESER_STATS_EN
    logic resync_evt_c;
    logic loss_evt_c;
    logic err_evt_c;

    assign resync_evt_c = link.sync_in & ~boundary_c & (state != ST_HUNT);
    assign loss_evt_c   = (state == ST_LOCKED) & (state_nxt == ST_HUNT);
    assign err_evt_c    = resync_evt_c | loss_evt_c | drop_c;

    // Saturating error counter; simultaneous events count once.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            link.err_cnt <= ERR_W'(0);
        end else if (err_evt_c && (link.err_cnt != {ERR_W{1'b1}})) begin
            link.err_cnt <= link.err_cnt + ERR_W'(1);
        end
    end
`else
    assign link.err_cnt = ERR_W'(0);
`endif

endmodule

// File: tb/tb_radio_deserializer.sv
// Directed bench for radio_deserializer: frame-level vector table for lock
// acquisition and streaming, plus hand-written multi-cycle corner sequences.
module tb_radio_deserializer;
`ifdef RADIO_DESER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic sys_clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    radio_deserializer_if bus ();

    radio_deserializer #(
        .LOCK_COUNT (4),
        .LOSS_COUNT (2)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .link    (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [7:0] word;
        logic       sync;
        logic       exp_locked;
        logic       exp_valid;
        logic [7:0] exp_sample;
    } frame_vec_t;

    frame_vec_t vecs [9];

    function automatic logic [7:0] exp_err(input int n);
        return STATS ? 8'(n) : 8'h00;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    // One bit period: drive inputs, pass the active edge, settle.
    task automatic cycle(input logic d, input logic s);
        bus.data_in = d;
        bus.sync_in = s;
        @(posedge sys_clk);
        #1;
    endtask

    // One 8-bit frame, LSB first, optional sync on bit 0, ready per bit.
    task automatic send_frame(input logic [7:0] w, input logic s, input logic [7:0] rdy);
        for (int b = 0; b < 8; b++) begin
            bus.sample_ready = rdy[b];
            cycle(w[b], s && (b == 0));
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] smp, input logic vld,
                             input logic lck, input logic ovf, input logic [7:0] err);
        check({tag, " sample"},   bus.sample,             smp);
        check({tag, " valid"},    8'(bus.sample_valid),   8'(vld));
        check({tag, " locked"},   8'(bus.locked),         8'(lck));
        check({tag, " overflow"}, 8'(bus.overflow),       8'(ovf));
        check({tag, " err_cnt"},  bus.err_cnt,            err);
    endtask

    initial begin
        logic [7:0] w;
        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5};
        vecs[4] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5};
        vecs[5] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C};
        vecs[6] = '{8'h96, 1'b0, 1'b1, 1'b1, 8'h96};
        vecs[7] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A};
        vecs[8] = '{8'h0F, 1'b1, 1'b1, 1'b1, 8'h0F};

        // Reset state
        rst              = 1'b1;
        bus.data_in      = 1'b0;
        bus.sync_in      = 1'b0;
        bus.sample_ready = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        rst = 1'b0;
        check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, exp_err(0));

        // Lock acquisition and streaming, one missing sync tolerated
        for (int i = 0; i < 9; i++) begin
            send_frame(vecs[i].word, vecs[i].sync, 8'hFF);
            check($sformatf("row%0d locked", i), 8'(bus.locked),       8'(vecs[i].exp_locked));
            check($sformatf("row%0d valid", i),  8'(bus.sample_valid), 8'(vecs[i].exp_valid));
            check($sformatf("row%0d sample", i), bus.sample,           vecs[i].exp_sample);
            check($sformatf("row%0d ovf", i),    8'(bus.overflow),     8'h00);
        end

        // Full FIFO: pop and push in the same cycle keeps order, no drop
        send_frame(8'h21, 1'b1, 8'h00);
        check_all("full", 8'h0F, 1'b1, 1'b1, 1'b0, exp_err(0));
        send_frame(8'h22, 1'b1, 8'h80);
        check_all("pushpop", 8'h21, 1'b1, 1'b1, 1'b0, exp_err(0));
        send_frame(8'h23, 1'b1, 8'h01);
        check_all("order", 8'h22, 1'b1, 1'b1, 1'b0, exp_err(0));

        // Overflow: 01,02 kept, 03 dropped
        send_frame(8'h01, 1'b1, 8'h03);
        check_all("ovf w01", 8'h01, 1'b1, 1'b1, 1'b0, exp_err(0));
        send_frame(8'h02, 1'b1, 8'h00);
        send_frame(8'h03, 1'b1, 8'h00);
        check_all("ovf drop", 8'h01, 1'b1, 1'b1, 1'b1, exp_err(1));
        w = 8'h11;
        bus.sample_ready = 1'b1;
        cycle(w[0], 1'b1);
        check("drain second", bus.sample, 8'h02);
        check("drain valid1", 8'(bus.sample_valid), 8'h01);
        cycle(w[1], 1'b0);
        check("drain empty", 8'(bus.sample_valid), 8'h00);
        for (int b = 2; b < 8; b++) cycle(w[b], 1'b0);
        check_all("after drain", 8'h11, 1'b1, 1'b1, 1'b1, exp_err(1));

        // Loss of lock after two missing syncs
        send_frame(8'h31, 1'b0, 8'hFF);
        check_all("miss1", 8'h31, 1'b1, 1'b1, 1'b1, exp_err(1));
        w = 8'h32;
        cycle(w[0], 1'b0);
        check("loss locked", 8'(bus.locked), 8'h00);
        check("loss err", bus.err_cnt, exp_err(2));
        for (int b = 1; b < 8; b++) cycle(w[b], 1'b0);
        check("loss no push", 8'(bus.sample_valid), 8'h00);

        // Relock, then off-phase sync at bitcnt 3
        send_frame(8'h41, 1'b1, 8'hFF);
        send_frame(8'h42, 1'b1, 8'hFF);
        send_frame(8'h43, 1'b1, 8'hFF);
        check("relock pre", 8'(bus.locked), 8'h00);
        send_frame(8'h44, 1'b1, 8'hFF);
        check_all("relock", 8'h44, 1'b1, 1'b1, 1'b1, exp_err(2));
        w = 8'h45;
        cycle(w[0], 1'b1);
        cycle(w[1], 1'b0);
        cycle(w[2], 1'b0);
        w = 8'h46;
        cycle(w[0], 1'b1);
        check("resync locked", 8'(bus.locked), 8'h00);
        check("resync err", bus.err_cnt, exp_err(3));
        for (int b = 1; b < 8; b++) cycle(w[b], 1'b0);
        check("resync dropped", 8'(bus.sample_valid), 8'h00);
        send_frame(8'h47, 1'b1, 8'hFF);
        send_frame(8'h48, 1'b1, 8'hFF);
        check("phase2 locked", 8'(bus.locked), 8'h00);
        send_frame(8'h49, 1'b1, 8'hFF);
        check_all("phase3", 8'h49, 1'b1, 1'b1, 1'b1, exp_err(3));

        // Reset mid-frame at bitcnt 4 with one word queued
        w = 8'h51;
        bus.sample_ready = 1'b0;
        for (int b = 0; b < 4; b++) cycle(w[b], b == 0);
        check("held sample", bus.sample, 8'h49);
        rst = 1'b1;
        cycle(w[4], 1'b0);
        rst = 1'b0;
        check_all("midreset", 8'h00, 1'b0, 1'b0, 1'b0, exp_err(0));
        bus.sample_ready = 1'b1;
        repeat (3) cycle(1'b1, 1'b0);
        check("hunt idle", 8'(bus.sample_valid), 8'h00);
        send_frame(8'h61, 1'b1, 8'hFF);
        send_frame(8'h62, 1'b1, 8'hFF);
        send_frame(8'h63, 1'b1, 8'hFF);
        check("post rst pre", 8'(bus.locked), 8'h00);
        send_frame(8'h64, 1'b1, 8'hFF);
        check_all("post rst lock", 8'h64, 1'b1, 1'b1, 1'b0, exp_err(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net in case the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
